// File: rtl/sr_drive_pkg.sv
// sr_drive_pkg: shared types for the SR flip-flop drive controller.
//   state_e : controller states (IDLE, DRIVE, CHECK, GAP)
//   op_e    : latched command (OP_SET drives s, OP_CLR drives r)
//   max2    : elaboration-time helper for sizing the shared timer
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_cyc_timer.sv
// sr_cyc_timer: loadable down-counter with a terminal-count flag.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : value to load; done_o rises after load_val_i further cycles
//   done_o     : counter is at zero
module sr_cyc_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns held set/clear requests into timed s/r pulses for an
// SR flip-flop, guaranteeing s_out and r_out are never high together, with a
// minimum idle gap between commands.
// Optional feature macro: SR_VERIFY_EN adds a one-cycle CHECK state that
// compares q_in with the commanded value and sets a sticky err_mismatch.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   set_req      : set request, held until req_ack
//   clr_req      : clear request, held until req_ack (wins over set_req)
//   req_ack      : 1-cycle accept pulse
//   conflict     : 1-cycle pulse when both requests were high on accept
//   s_out, r_out : drives to the FF s/r inputs
//   q_in         : FF q feedback (only used with SR_VERIFY_EN)
//   busy         : controller not in IDLE
//   err_mismatch : sticky feedback mismatch flag
//   cmd_cnt      : completed-command counter, wraps
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_req,
  input  logic             clr_req,
  output logic             req_ack,
  output logic             conflict,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in,
  output logic             busy,
  output logic             err_mismatch,
  output logic [CNT_W-1:0] cmd_cnt
);

  // State | meaning
  // IDLE  | waiting for a request; the only state that accepts one
  // DRIVE | s_out or r_out high for HOLD_CYC cycles
  // CHECK | one cycle, outputs low, q_in compared (SR_VERIFY_EN only)
  // GAP   | GAP_CYC cycles with outputs low (skipped when GAP_CYC=0)

  localparam int unsigned TMR_W = $clog2(max2(HOLD_CYC, GAP_CYC) + 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = (GAP_CYC > 0) ? TMR_W'(GAP_CYC - 1) : '0;

  state_e           state_q, state_d;
  op_e              op_q;
  logic             ack_q, conflict_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  assign accept = (state_q == IDLE) && (set_req || clr_req);

  sr_cyc_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      DRIVE: begin
        if (tmr_done) begin
`ifdef SR_VERIFY_EN
          state_d = CHECK;
`else
          if (GAP_CYC > 0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
      CHECK: begin
        if (GAP_CYC > 0) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (tmr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so an async reset
  // drops s_out/r_out immediately; the one-hot op makes both-high impossible.
  always_comb begin
    s_out = (state_q == DRIVE) && (op_q == OP_SET);
    r_out = (state_q == DRIVE) && (op_q == OP_CLR);
    busy  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_CLR;
      ack_q      <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ack_q      <= accept;
      conflict_q <= accept && set_req && clr_req;
      if (accept)
        op_q <= clr_req ? OP_CLR : OP_SET;
      if ((state_q == DRIVE) && tmr_done)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign req_ack  = ack_q;
  assign conflict = conflict_q;
  assign cmd_cnt  = cnt_q;

`ifdef SR_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if ((state_q == CHECK) && (q_in != logic'(op_q)))
      err_q <= 1'b1;
  end

  assign err_mismatch = err_q;
`else
  logic unused_q_in;
  assign unused_q_in  = q_in;
  assign err_mismatch = 1'b0;
`endif

endmodule
